// File: rtl/goe_trigger_ctrl.sv
// goe_trigger_ctrl: qualifies GOE LUT trigger classes and sequences the MAROC hold/readout/holdoff cycle
module goe_trigger_ctrl #(
    parameter int DELAY_W   = 8,
    parameter int HOLDOFF_W = 16,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           spo,
    input  logic [1:0]           class_mask,
    input  logic [DELAY_W-1:0]   hold_delay,
    input  logic [HOLDOFF_W-1:0] holdoff,
    input  logic                 rd_done,
    output logic                 hold,
    output logic                 trig_stb,
    output logic [1:0]           trig_class,
    output logic                 busy,
    output logic [CNT_W-1:0]     trig_cnt,
    output logic [CNT_W-1:0]     miss_cnt
);
    typedef enum logic [1:0] {IDLE, DELAY, HOLD, HOLDOFF} state_t;
    state_t state, state_n;
    logic [1:0] s1, s2;
    logic [DELAY_W-1:0] dly_cnt, dly_n;
    logic [HOLDOFF_W-1:0] ho_cnt, ho_n;
    logic evt, accept, miss;
    assign evt    = (s1 != 2'b00) && (s2 == 2'b00);
    assign accept = evt && en && state == IDLE;
    assign miss   = evt && en && state != IDLE;
    assign busy   = state != IDLE;
    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    // next state; delay/holdoff are latched at acceptance so later input changes cannot disturb a sequence
    always_comb begin
        state_n = state;
        dly_n   = dly_cnt;
        ho_n    = ho_cnt;
        case (state)
            IDLE: if (accept) begin
                dly_n   = hold_delay;
                ho_n    = holdoff;
                state_n = hold_delay == '0 ? HOLD : DELAY;
            end
            DELAY: begin
                dly_n   = dly_cnt - DELAY_W'(1);
                state_n = dly_cnt == DELAY_W'(1) ? HOLD : DELAY;
            end
            HOLD: if (rd_done) state_n = ho_cnt == '0 ? IDLE : HOLDOFF;
            HOLDOFF: begin
                ho_n    = ho_cnt - HOLDOFF_W'(1);
                state_n = ho_cnt == HOLDOFF_W'(1) ? IDLE : HOLDOFF;
            end
            default: state_n = IDLE;
        endcase
    end
    // input edge pipeline, registered outputs and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= '0;
            s2         <= '0;
            dly_cnt    <= '0;
            ho_cnt     <= '0;
            hold       <= 1'b0;
            trig_stb   <= 1'b0;
            trig_class <= '0;
            trig_cnt   <= '0;
            miss_cnt   <= '0;
        end else begin
            s1       <= spo & class_mask;
            s2       <= s1;
            dly_cnt  <= dly_n;
            ho_cnt   <= ho_n;
            hold     <= state_n == HOLD;
            trig_stb <= accept;
            if (accept) trig_class <= s1;
            if (accept && trig_cnt != '1) trig_cnt <= trig_cnt + CNT_W'(1);
            if (miss && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
        end
    end
endmodule
